uart_echo_fifo: RTL and testbench

Elastic byte buffer between the UART receiver and the UART transmitter in the loopback path. It accepts every byte the receiver reports (`o_RX_DV` / `o_RX_Byte`) and replays them to the transmitter one at a time, waiting for each transmission to finish before starting the next. Back-to-back received bytes therefore are no longer lost while the transmitter is busy. It also holds the most recently received byte for the seven-segment display path, and flags sticky overflow when the buffer is full.

---
 rtl/uart_echo_fifo.sv | 139 +++++++++++++
 tb/tb_uart_echo_fifo.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo_fifo.sv
// -----------------------------------------------------------------------------
// uart_echo_fifo
//
// Elastic byte buffer that sits between a UART receiver and a UART transmitter
// in a loopback path. Every received byte is queued. Queued bytes are replayed
// to the transmitter one at a time, and each new launch waits for the previous
// transmission to report completion. The most recently accepted byte is held
// for a display path. A sticky flag records any byte dropped because the
// buffer was full.
//
// Ports
//   i_Clk            system clock, rising edge
//   i_Reset          synchronous active-high reset
//   i_RX_DV          one-cycle strobe: i_RX_Byte is valid
//   i_RX_Byte        received byte
//   i_TX_Done        one-cycle strobe from the transmitter at the end of the stop bit
//   o_TX_DV          one-cycle launch strobe to the transmitter
//   o_TX_Byte        byte to transmit, held until the next launch
//   o_Last_Byte      last byte accepted into the buffer
//   o_Count          occupancy, 0..g_DEPTH
//   o_Empty          occupancy is zero
//   o_Full           occupancy is g_DEPTH
//   o_Overflow       sticky: a byte was dropped
//   i_Clear_Overflow clears o_Overflow (a drop in the same cycle wins)
// -----------------------------------------------------------------------------
module uart_echo_fifo #(
   parameter int g_DEPTH     = 16,
   parameter int g_ADDR_BITS = 4
) (
   input  logic                   i_Clk,
   input  logic                   i_Reset,
   input  logic                   i_RX_DV,
   input  logic [7:0]             i_RX_Byte,
   input  logic                   i_TX_Done,
   output logic                   o_TX_DV,
   output logic [7:0]             o_TX_Byte,
   output logic [7:0]             o_Last_Byte,
   output logic [g_ADDR_BITS:0]   o_Count,
   output logic                   o_Empty,
   output logic                   o_Full,
   output logic                   o_Overflow,
   input  logic                   i_Clear_Overflow
);

   localparam int CW = g_ADDR_BITS + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(g_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      WAIT_DONE
   } state_t;

   state_t                 state;
   state_t                 state_next;
   logic [7:0]             mem [g_DEPTH];
   logic [g_ADDR_BITS-1:0] wr_ptr;
   logic [g_ADDR_BITS-1:0] rd_ptr;
   logic                   push;
   logic                   drop;
   logic                   pop;

   assign o_Empty = (o_Count == '0);
   assign o_Full  = (o_Count == FULL_COUNT);

   // The full test uses the occupancy before this edge, so a pop on the same
   // edge never makes room for an incoming byte.
   assign push = i_RX_DV & ~o_Full;
   assign drop = i_RX_DV &  o_Full;

   // Drain FSM: a pop is the IDLE->SEND transition itself.
   // NOTE: every signal written here gets a default first; a path that leaves
   // one unassigned would infer a latch.
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      case (state)
         IDLE: begin
            if (!o_Empty) begin
               state_next = SEND;
               pop        = 1'b1;
            end
         end
         SEND:      state_next = WAIT_DONE;
         WAIT_DONE: if (i_TX_Done) state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   // NOTE: the byte array carries no reset; its contents are unreachable until
   // written, and leaving it out of reset lets it map onto plain storage.
   always_ff @(posedge i_Clk) begin
      if (push) begin
         mem[wr_ptr] <= i_RX_Byte;
      end
   end

   // NOTE: state is updated with non-blocking assignments only, so every
   // register samples values from before the edge regardless of block order.
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         state       <= IDLE;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         o_Count     <= '0;
         o_TX_DV     <= 1'b0;
         o_TX_Byte   <= 8'h00;
         o_Last_Byte <= 8'h00;
         o_Overflow  <= 1'b0;
      end else begin
         state   <= state_next;
         o_TX_DV <= pop;

         if (push) begin
            wr_ptr      <= wr_ptr + g_ADDR_BITS'(1);
            o_Last_Byte <= i_RX_Byte;
         end

         if (pop) begin
            rd_ptr    <= rd_ptr + g_ADDR_BITS'(1);
            o_TX_Byte <= mem[rd_ptr];
         end

         case ({push, pop})
            2'b10:   o_Count <= o_Count + CW'(1);
            2'b01:   o_Count <= o_Count - CW'(1);
            default: o_Count <= o_Count;
         endcase

         // A drop in the same cycle as a clear leaves the flag set.
         if (drop) begin
            o_Overflow <= 1'b1;
         end else if (i_Clear_Overflow) begin
            o_Overflow <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_echo_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_echo_fifo
//
// Scoreboard bench for uart_echo_fifo. A reference model, driven only by the
// DUT inputs, tracks the buffer as a byte queue and the transmitter handshake
// as a ready flag; every launch it predicts is queued with the edge it is due
// on. A monitor on the falling edge pops that queue whenever o_TX_DV is seen
// and compares byte and timing, and also compares the status outputs. A small
// transmitter emulator answers each launch with i_TX_Done after a latency,
// or holds off completely when tx_hold is set.
// -----------------------------------------------------------------------------
module tb_uart_echo_fifo;

   localparam int DEPTH = 16;
   localparam int AB    = 4;

   logic          i_Clk = 1'b0;
   logic          i_Reset;
   logic          i_RX_DV;
   logic [7:0]    i_RX_Byte;
   logic          i_TX_Done;
   logic          o_TX_DV;
   logic [7:0]    o_TX_Byte;
   logic [7:0]    o_Last_Byte;
   logic [AB:0]   o_Count;
   logic          o_Empty;
   logic          o_Full;
   logic          o_Overflow;
   logic          i_Clear_Overflow;

   uart_echo_fifo #(
      .g_DEPTH     (DEPTH),
      .g_ADDR_BITS (AB)
   ) dut (
      .i_Clk            (i_Clk),
      .i_Reset          (i_Reset),
      .i_RX_DV          (i_RX_DV),
      .i_RX_Byte        (i_RX_Byte),
      .i_TX_Done        (i_TX_Done),
      .o_TX_DV          (o_TX_DV),
      .o_TX_Byte        (o_TX_Byte),
      .o_Last_Byte      (o_Last_Byte),
      .o_Count          (o_Count),
      .o_Empty          (o_Empty),
      .o_Full           (o_Full),
      .o_Overflow       (o_Overflow),
      .i_Clear_Overflow (i_Clear_Overflow)
   );

   always #5 i_Clk = ~i_Clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input int actual, input int expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, actual, expected, $time);
      end
   endtask

   // ---------------- transmitter emulator ----------------
   logic stray_done  = 1'b0;
   logic tx_done_emu = 1'b0;
   logic tx_hold     = 1'b0;
   int   tx_latency  = 20;
   int   tx_cnt      = 0;

   assign i_TX_Done = tx_done_emu | stray_done;

   always @(negedge i_Clk) begin
      tx_done_emu = 1'b0;
      if (tx_cnt > 0) begin
         tx_cnt--;
         if (tx_cnt == 0) tx_done_emu = 1'b1;
      end
      if (o_TX_DV === 1'b1 && !tx_hold) tx_cnt = tx_latency;
   end

   // ---------------- reference model ----------------
   typedef struct {
      logic [7:0] data;
      int         edge_no;
   } exp_t;

   logic [7:0] mq[$];        // bytes held in the buffer
   exp_t       exp_q[$];     // predicted launches
   int         edge_n        = 0;
   bit         m_ready       = 1'b1;  // transmitter free to accept a launch
   int         m_launch_edge = 0;
   logic [7:0] m_last        = 8'h00;
   logic [7:0] m_txbyte      = 8'h00;
   bit         m_ovf         = 1'b0;

   always @(posedge i_Clk) begin : model
      int         sz;
      bit         do_pop;
      bit         drop_now;
      logic [7:0] b;
      edge_n++;
      if (i_Reset) begin
         mq.delete();
         m_ready  = 1'b1;
         m_last   = 8'h00;
         m_txbyte = 8'h00;
         m_ovf    = 1'b0;
      end else begin
         sz       = mq.size();
         do_pop   = m_ready && sz > 0;
         drop_now = i_RX_DV && sz == DEPTH;
         if (do_pop) begin
            b        = mq.pop_front();
            m_txbyte = b;
            exp_q.push_back('{data: b, edge_no: edge_n});
            m_ready       = 1'b0;
            m_launch_edge = edge_n;
         end else if (!m_ready && i_TX_Done && edge_n >= m_launch_edge + 2) begin
            // completion counts only once the one-cycle launch slot is over
            m_ready = 1'b1;
         end
         if (i_RX_DV && !drop_now) begin
            mq.push_back(i_RX_Byte);
            m_last = i_RX_Byte;
         end
         if (drop_now) m_ovf = 1'b1;
         else if (i_Clear_Overflow) m_ovf = 1'b0;
      end
   end

   // ---------------- monitor ----------------
   int         launches    = 0;
   logic [7:0] last_launch = 8'h00;
   logic       prev_dv     = 1'b0;

   always @(negedge i_Clk) begin : monitor
      bit   due;
      exp_t e;
      if (edge_n > 0) begin
         due = exp_q.size() > 0 && exp_q[0].edge_no == edge_n;
         check("tx_dv", o_TX_DV, due);
         check("tx_dv_back_to_back", prev_dv & o_TX_DV, 0);
         if (o_TX_DV === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("launch_byte", o_TX_Byte, e.data);
            check("launch_edge", edge_n, e.edge_no);
            launches++;
            last_launch = o_TX_Byte;
         end else if (due) begin
            void'(exp_q.pop_front());
         end
         check("count", o_Count, mq.size());
         check("empty", o_Empty, mq.size() == 0);
         check("full", o_Full, mq.size() == DEPTH);
         check("last_byte", o_Last_Byte, m_last);
         check("overflow", o_Overflow, m_ovf);
         check("tx_byte", o_TX_Byte, m_txbyte);
         prev_dv = o_TX_DV;
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(negedge i_Clk);
   endtask

   task automatic pulse_done();
      stray_done = 1'b1;
      tick();
      stray_done = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (!(exp_q.size() == 0 && mq.size() == 0 && m_ready && tx_cnt == 0) && n < budget) begin
         tick();
         n++;
      end
      check("drain_timeout", n < budget, 1);
   endtask

   initial begin : stim
      int l0;
      i_Reset          = 1'b1;
      i_RX_DV          = 1'b0;
      i_RX_Byte        = 8'h00;
      i_Clear_Overflow = 1'b0;

      // reset with random inputs
      for (int i = 0; i < 2; i++) begin
         i_RX_DV          = 1'($urandom);
         i_RX_Byte        = 8'($urandom);
         i_Clear_Overflow = 1'($urandom);
         stray_done       = 1'($urandom);
         tick();
      end
      check("rst_count", o_Count, 0);
      check("rst_empty", o_Empty, 1);
      check("rst_full", o_Full, 0);
      check("rst_tx_byte", o_TX_Byte, 8'h00);
      check("rst_last_byte", o_Last_Byte, 8'h00);
      check("rst_overflow", o_Overflow, 0);
      i_Reset          = 1'b0;
      i_RX_DV          = 1'b0;
      i_Clear_Overflow = 1'b0;
      stray_done       = 1'b0;
      repeat (10) begin
         tick();
         check("rst_no_launch", o_TX_DV, 0);
      end

      // single byte pass-through
      i_RX_DV = 1'b1; i_RX_Byte = 8'hA5;
      tick();
      i_RX_DV = 1'b0;
      check("single_last", o_Last_Byte, 8'hA5);
      check("single_count_e", o_Count, 1);
      tick();
      check("single_tx_dv", o_TX_DV, 1);
      check("single_tx_byte", o_TX_Byte, 8'hA5);
      check("single_count_e1", o_Count, 0);
      tick();
      check("single_tx_dv_low", o_TX_DV, 0);
      wait_idle(100);

      // burst against a slow transmitter
      l0 = launches;
      for (int b = 1; b <= 5; b++) begin
         i_RX_DV = 1'b1; i_RX_Byte = 8'(b);
         tick();
      end
      i_RX_DV = 1'b0;
      wait_idle(300);
      check("burst_launches", launches - l0, 5);
      check("burst_last", last_launch, 8'h05);

      // overflow with the transmitter held
      tx_hold = 1'b1;
      for (int b = 0; b < 18; b++) begin
         i_RX_DV = 1'b1; i_RX_Byte = 8'(8'h10 + b);
         tick();
      end
      i_RX_DV = 1'b0;
      check("ovf_full", o_Full, 1);
      check("ovf_count", o_Count, 16);
      check("ovf_flag", o_Overflow, 1);
      check("ovf_last", o_Last_Byte, 8'h20);
      i_Clear_Overflow = 1'b1;
      tick();
      i_Clear_Overflow = 1'b0;
      check("ovf_cleared", o_Overflow, 0);
      tx_hold = 1'b0; tx_latency = 3;
      pulse_done();
      wait_idle(400);
      check("ovf_drain_last", last_launch, 8'h20);

      // push on the same edge as a pop
      tx_hold = 1'b1;
      for (int b = 0; b < 4; b++) begin
         i_RX_DV = 1'b1; i_RX_Byte = 8'(8'h31 + b);
         tick();
      end
      i_RX_DV = 1'b0;
      tick(); tick();
      check("simul_pre_count", o_Count, 3);
      pulse_done();
      i_RX_DV = 1'b1; i_RX_Byte = 8'h7E;
      tick();
      i_RX_DV = 1'b0;
      check("simul_count", o_Count, 3);
      check("simul_tx_byte", o_TX_Byte, 8'h32);
      tick();
      tx_hold = 1'b0; tx_latency = 4;
      pulse_done();
      wait_idle(200);
      check("simul_last_tx", last_launch, 8'h7E);

      // reset while waiting for completion
      tx_hold = 1'b1;
      for (int b = 0; b < 5; b++) begin
         i_RX_DV = 1'b1; i_RX_Byte = 8'(8'h41 + b);
         tick();
      end
      i_RX_DV = 1'b0;
      tick(); tick();
      check("rstw_pre_count", o_Count, 4);
      i_Reset = 1'b1;
      tick(); tick();
      i_Reset = 1'b0;
      pulse_done();
      repeat (10) begin
         tick();
         check("rstw_no_launch", o_TX_DV, 0);
      end
      check("rstw_empty", o_Empty, 1);
      tx_hold = 1'b0;

      // random traffic
      for (int i = 0; i < 400; i++) begin
         i_RX_DV          = ($urandom_range(0, 2) == 0);
         i_RX_Byte        = 8'($urandom);
         i_Clear_Overflow = ($urandom_range(0, 15) == 0);
         stray_done       = ($urandom_range(0, 19) == 0);
         tx_latency       = $urandom_range(1, 8);
         tick();
      end
      i_RX_DV          = 1'b0;
      i_Clear_Overflow = 1'b0;
      stray_done       = 1'b0;
      wait_idle(600);
      check("final_pending", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
